// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, next-PC select and idle-loop halt detection for the single-cycle core
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              fetch_valid,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] jump_tgt;
    logic [31:0] br_tgt;
    logic [31:0] next_pc;
    logic        self_jump;

    assign pc_plus4  = pc + 32'd4;
    assign jump_tgt  = {pc_plus4[31:28], jump_index, 2'b00};
    assign br_tgt    = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign next_pc   = jump ? jump_tgt : (branch_taken ? br_tgt : pc_plus4);
    assign self_jump = jump && (jump_tgt == pc);
    // Word address aliases once pc leaves the imem window; pc keeps all 32 bits.
    assign imem_addr = pc[ADDR_W+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC_ALIGNED;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        pc <= next_pc;
                        if (fetch_count != 32'hFFFF_FFFF) begin
                            fetch_count <= fetch_count + 32'd1;
                        end
                        // The self-jump fetch itself still retires before fetch stops.
                        if (self_jump) begin
                            state       <= HALT;
                            fetch_valid <= 1'b0;
                            halted      <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    fetch_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule
